muldiv_seq_ctrl: RTL

Sequencing controller for the EX-stage multiply/divide datapath. It detects RV32M instructions in EX and latches their forwarded operands. It issues them to the multi-cycle muldiv datapath over a start/done handshake and holds the pipeline stall until the result is captured. Divide-by-zero and signed-overflow cases are resolved locally without issuing, and ops killed by a flush are drained cleanly.

---
 rtl/muldiv_seq_ctrl_pkg.sv | 24 ++
 rtl/muldiv_seq_ctrl_if.sv | 21 ++
 rtl/muldiv_special_case.sv | 43 ++++
 rtl/muldiv_seq_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared types and RV32M decode constants for the EX-stage muldiv sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } md_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// Start/done handshake between the sequencer (master) and the muldiv datapath (slave).
interface muldiv_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            md_start_o;
    logic [2:0]      md_op_o;
    logic [XLEN-1:0] md_in1_o;
    logic [XLEN-1:0] md_in2_o;
    logic            md_done_i;
    logic [XLEN-1:0] md_result_i;

    modport master (
        output md_start_o, md_op_o, md_in1_o, md_in2_o,
        input  md_done_i, md_result_i
    );

    modport slave (
        input  md_start_o, md_op_o, md_in1_o, md_in2_o,
        output md_done_i, md_result_i
    );
endinterface

// File: rtl/muldiv_special_case.sv
// Resolves divide-by-zero and signed-overflow divides without the datapath.
module muldiv_special_case
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] in1_i,
    input  logic [XLEN-1:0] in2_i,
    output logic            is_special_o,
    output logic [XLEN-1:0] special_result_o
);

    logic is_div_family;
    logic is_rem;
    logic is_signed;
    logic div_zero;
    logic overflow;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        is_special_o     = 1'b0;
        special_result_o = '0;

        is_div_family = (funct3_i == F3_DIV) || (funct3_i == F3_DIVU) ||
                        (funct3_i == F3_REM) || (funct3_i == F3_REMU);
        is_rem        = (funct3_i == F3_REM) || (funct3_i == F3_REMU);
        is_signed     = (funct3_i == F3_DIV) || (funct3_i == F3_REM);

        div_zero = is_div_family && (in2_i == '0);
        overflow = is_div_family && is_signed &&
                   (in1_i == {1'b1, {(XLEN-1){1'b0}}}) && (in2_i == '1);

        if (div_zero) begin
            is_special_o     = 1'b1;
            special_result_o = is_rem ? in1_i : '1;
        end else if (overflow) begin
            is_special_o     = 1'b1;
            special_result_o = is_rem ? '0 : in1_i;
        end
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// EX-stage RV32M sequencer: latches operands, issues to the datapath, stalls until capture.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [XLEN-1:0]   in1_i,
    input  logic [XLEN-1:0]   in2_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [XLEN-1:0]   result_o,
    output logic              result_valid_o,
    output logic              err_o,
    muldiv_seq_ctrl_if.master md
);

    localparam int CW = $clog2(TIMEOUT + 1);

    md_state_e       state_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] in1_q;
    logic [XLEN-1:0] in2_q;
    logic [XLEN-1:0] result_q;
    logic [CW-1:0]   cnt_q;
    logic            err_q;

    logic            is_op;
    logic            is_special;
    logic [XLEN-1:0] special_result;

    assign is_op = valid_i && (opcode_i == OPCODE_R) && (funct7_i == FUNCT7_MULDIV);

    muldiv_special_case #(.XLEN(XLEN)) u_special (
        .funct3_i         (funct3_i),
        .in1_i            (in1_i),
        .in2_i            (in2_i),
        .is_special_o     (is_special),
        .special_result_o (special_result)
    );

    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            ST_IDLE:  stall_o = is_op && !flush_i;
            ST_ISSUE,
            ST_WAIT:  stall_o = 1'b1;
            ST_DRAIN: stall_o = is_op;
            default:  stall_o = 1'b0;
        endcase
    end

    assign md.md_start_o  = (state_q == ST_ISSUE) && !flush_i;
    assign result_valid_o = (state_q == ST_DONE) && !flush_i;
    assign md.md_op_o     = op_q;
    assign md.md_in1_o    = in1_q;
    assign md.md_in2_o    = in2_q;
    assign result_o       = result_q;
    assign err_o          = err_q;

    // NOTE: all FSM state is updated with non-blocking assignments in this one clocked block.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_op && !flush_i) begin
                        op_q  <= funct3_i;
                        in1_q <= in1_i;
                        in2_q <= in2_i;
                        if (is_special) begin
                            result_q <= special_result;
                            state_q  <= ST_DONE;
                        end else begin
                            state_q  <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (md.md_done_i) begin
                        if (flush_i) begin
                            state_q <= ST_IDLE;
                        end else begin
                            result_q <= md.md_result_i;
                            state_q  <= ST_DONE;
                        end
                    end else if (flush_i) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        // Saturate so a hung datapath leaves err_o set without wrapping.
                        if (cnt_q != CW'(TIMEOUT)) cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(TIMEOUT - 1)) err_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (md.md_done_i) state_q <= ST_IDLE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
